// File: rtl/intmul_pkg.sv
// Shared constants and types for the 32x32 integer multiplier, its result
// buffer and their testbenches.
package intmul_pkg;

  localparam int OPND_W           = 32;
  localparam int PROD_W           = 64;
  localparam int RESBUF_DEPTH_DEF = 4;

  typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/intmul_credit_ctr.sv
// Issue-credit counter: tracks operations in flight inside the multiplier and
// grants issue only when every in-flight product is guaranteed a FIFO slot.
module intmul_credit_ctr
  import intmul_pkg::*;
#(
  parameter int DEPTH = RESBUF_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue,
  input  logic                         commit,
  input  logic [$clog2(DEPTH+1)-1:0]   occ,
  output logic                         issue_ok,
  output logic                         inf_zero
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] INF_MAX   = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(DEPTH);

  logic [CW-1:0] inf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inf <= '0;
    end else if (issue && !commit && inf != INF_MAX) begin
      inf <= inf + 1'b1;
    end else if (commit && !issue && inf != '0) begin
      inf <= inf - 1'b1;
    end
  end

  // Extra bit so occ + inf cannot wrap before the compare.
  assign issue_ok = ({1'b0, occ} + {1'b0, inf}) < DEPTH_EXT;
  assign inf_zero = (inf == '0);

endmodule

// File: rtl/intmul_result_buffer.sv
// Product FIFO between the multiplier and its consumer, with issue credits.
// Define INTMUL_RESBUF_BYPASS_EN for a same-cycle empty-FIFO bypass path.
module intmul_result_buffer
  import intmul_pkg::*;
#(
  parameter int DEPTH  = RESBUF_DEPTH_DEF,
  parameter int PROD_W = intmul_pkg::PROD_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue,
  output logic                       issue_ok,
  input  logic                       commit,
  input  logic [PROD_W-1:0]          longP,
  output logic                       res_val,
  input  logic                       res_rdy,
  output logic [PROD_W-1:0]          res,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);

  logic [PROD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     occ;
  logic              fifo_empty, fifo_full, fifo_pop, push, bypass_take;
  logic              inf_zero, err_set;

  intmul_credit_ctr #(.DEPTH(DEPTH)) u_credit (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .commit   (commit),
    .occ      (occ),
    .issue_ok (issue_ok),
    .inf_zero (inf_zero)
  );

  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == OCC_FULL);
  assign fifo_pop   = !fifo_empty && res_rdy;

`ifdef INTMUL_RESBUF_BYPASS_EN
  assign bypass_take = fifo_empty && commit && res_rdy;
  assign res_val     = !fifo_empty || commit;
  assign res         = !fifo_empty ? mem[rp] : (commit ? longP : '0);
`else
  assign bypass_take = 1'b0;
  assign res_val     = !fifo_empty;
  assign res         = fifo_empty ? '0 : mem[rp];
`endif

  // A full FIFO still accepts a commit when the head leaves on the same edge.
  assign push    = commit && !bypass_take && (!fifo_full || fifo_pop);
  assign err_set = (issue && !issue_ok) || (commit && inf_zero) ||
                   (commit && fifo_full && !fifo_pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= longP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
      err <= 1'b0;
    end else begin
      if (push) begin
        wp <= (wp == PTR_LAST) ? '0 : wp + 1'b1;
      end
      if (fifo_pop) begin
        rp <= (rp == PTR_LAST) ? '0 : rp + 1'b1;
      end
      case ({push, fifo_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  assign count = occ;

endmodule

// File: tb/tb_intmul_result_buffer.sv
// Bench for intmul_result_buffer: directed scenarios plus random traffic
// compared against a queue-based model; follows INTMUL_RESBUF_BYPASS_EN.
module tb_intmul_result_buffer;
  import intmul_pkg::*;

  localparam int DEPTH = 4;
`ifdef INTMUL_RESBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        issue = 1'b0;
  logic        commit = 1'b0;
  logic        res_rdy = 1'b0;
  prod_t       longP = '0;
  logic        issue_ok, res_val, err;
  prod_t       res;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  prod_t q[$];
  int    m_inf = 0;
  bit    m_err = 1'b0;

  always #5 clk = ~clk;

  intmul_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .issue_ok (issue_ok),
    .commit   (commit),
    .longP    (longP),
    .res_val  (res_val),
    .res_rdy  (res_rdy),
    .res      (res),
    .count    (count),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit    mval;
    prod_t mres;
    mval = (q.size() > 0) || (BYP && commit);
    if (q.size() > 0)       mres = q[0];
    else if (BYP && commit) mres = longP;
    else                    mres = '0;
    chk({tag, ".res_val"},  res_val,  mval);
    chk({tag, ".res"},      res,      mres);
    chk({tag, ".count"},    count,    64'(q.size()));
    chk({tag, ".issue_ok"}, issue_ok, (q.size() + m_inf) < DEPTH);
    chk({tag, ".err"},      err,      m_err);
  endtask

  // Applies the buffer rules to the inputs present at the clock edge.
  task automatic model_update();
    int sz;
    bit pop, take;
    sz   = q.size();
    pop  = (sz > 0) && res_rdy;
    take = BYP && (sz == 0) && commit && res_rdy;
    if (issue && !((sz + m_inf) < DEPTH)) m_err = 1'b1;
    if (commit && m_inf == 0)             m_err = 1'b1;
    if (commit && sz == DEPTH && !pop)    m_err = 1'b1;
    if (pop) void'(q.pop_front());
    if (commit && !take && q.size() < DEPTH) q.push_back(longP);
    m_inf = m_inf + int'(issue) - int'(commit);
    if (m_inf < 0)     m_inf = 0;
    if (m_inf > DEPTH) m_inf = DEPTH;
  endtask

  task automatic step(input bit i, input bit c, input prod_t p, input bit r, input string tag);
    @(negedge clk);
    issue = i; commit = c; longP = p; res_rdy = r;
    #1 check_outputs(tag);
    @(posedge clk);
    model_update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    issue = 1'b0; commit = 1'b0; res_rdy = 1'b0; longP = '0;
    #1;
    chk("rst.res_val", res_val, 1'b0);
    chk("rst.count",   count,   3'd0);
    q.delete();
    m_inf = 0;
    m_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    prod_t exp_prod [4];
    exp_prod[0] = 64'h1;
    exp_prod[1] = 64'h2;
    exp_prod[2] = 64'h3;
    exp_prod[3] = 64'hFFFF_FFFF_0000_0001;

    // Reset then idle
    do_reset();
    #1;
    chk("idle.issue_ok", issue_ok, 1'b1);
    chk("idle.res_val",  res_val,  1'b0);
    chk("idle.count",    count,    3'd0);
    chk("idle.err",      err,      1'b0);
    step(0, 0, '0, 0, "idle");

    // Four issues, four delayed commits, then drain in order
    for (int k = 0; k < 4; k++) step(1, 0, '0, 0, "iss4");
    #1 chk("iss4.issue_ok_low", issue_ok, 1'b0);
    for (int k = 0; k < 4; k++) step(0, 1, exp_prod[k], 0, "cmt4");
    #1 chk("cmt4.count", count, 3'd4);
    for (int k = 0; k < 4; k++) begin
      #1 chk("drain.order", res, exp_prod[k]);
      step(0, 0, '0, 1, "drain");
      if (k == 0) begin
        #1 chk("drain.credit_back", issue_ok, 1'b1);
      end
    end

    // Back-to-back issue/commit with the consumer always ready
    for (int k = 0; k <= 20; k++) begin
      step(k < 20, k > 0, {$urandom, $urandom}, 1, "b2b");
      #1 chk("b2b.count_le1", count <= 3'd1, 1'b1);
    end
    step(0, 0, '0, 1, "b2b_tail");
    #1 chk("b2b.err", err, 1'b0);

    // Full FIFO: an extra commit without a pop is dropped
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 0, '0, 0, "fill_iss");
    for (int k = 0; k < 4; k++) step(0, 1, {$urandom, $urandom}, 0, "fill_cmt");
    step(0, 1, 64'hAA, 0, "full_drop");
    #1;
    chk("full.err",   err,   1'b1);
    chk("full.count", count, 3'd4);
    for (int k = 0; k < 4; k++) begin
      #1 chk("full.no_aa", res == 64'hAA, 1'b0);
      step(0, 0, '0, 1, "full_drain");
    end

    // Commit with nothing in flight on an empty FIFO
    do_reset();
    step(0, 1, 64'h55, 0, "orphan");
    #1;
    chk("orphan.err",   err,   1'b1);
    chk("orphan.count", count, 3'd1);

    // Reset while three products are buffered and one is in flight
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 0, '0, 0, "mid_iss");
    for (int k = 0; k < 3; k++) step(0, 1, {$urandom, $urandom}, 0, "mid_cmt");
    #1 chk("mid.count3", count, 3'd3);
    do_reset();
    #1 chk("mid.issue_ok", issue_ok, 1'b1);

`ifdef INTMUL_RESBUF_BYPASS_EN
    do_reset();
    step(1, 0, '0, 0, "byp_iss");
    @(negedge clk);
    issue = 1'b0; commit = 1'b1; longP = 64'h1234; res_rdy = 1'b1;
    #1;
    chk("byp.res",     res,     64'h1234);
    chk("byp.res_val", res_val, 1'b1);
    @(posedge clk);
    model_update();
    #1 chk("byp.count", count, 3'd0);
`endif

    // Random traffic that respects credits
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bit ri, rc;
      ri = ((q.size() + m_inf) < DEPTH) && ($urandom_range(0, 1) == 1);
      rc = (m_inf > 0) && ($urandom_range(0, 2) != 0);
      step(ri, rc, {$urandom, $urandom}, $urandom_range(0, 1) == 1, "rnd_legal");
    end

    // Unconstrained random traffic, including protocol violations
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           {$urandom, $urandom}, $urandom_range(0, 1) == 1, "rnd_any");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intmul_result_buffer.md
# intmul_result_buffer

Result buffer and credit manager directly downstream of the pipelined 32x32 integer multiplier. It captures each 64-bit product on the multiplier's `commit` pulse into a small FIFO and presents products to the consumer over a valid/ready handshake. The multiplier cannot be stalled once an operation has been issued, so the block grants issue credits: `issue_ok` guarantees a free FIFO slot for every operation in flight.

## Interface
- `DEPTH`, default 4: FIFO entries. Must be at least 1 and no more than 16.
- `PROD_W`, default 64: product width. Fixed by the multiplier.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `issue`  in  1  multiplier accepted an operand pair this cycle (`val_op & oprand_rdy`).
- `issue_ok`  out  1  upstream may issue this cycle.
- `commit`  in  1  multiplier product valid this cycle.
- `longP`  in  PROD_W  product from the multiplier.
- `res_val`  out  1  `res` holds a valid product.
- `res_rdy`  in  1  consumer takes `res` on this edge when `res_val` is high.
- `res`  out  PROD_W  oldest buffered product.
- `count`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `err`  out  1  sticky protocol-error flag.

## Operation
- State:
  - circular FIFO of DEPTH entries;
  - write pointer `wp` and read pointer `rp`, each wrapping modulo DEPTH;
  - occupancy `occ`, range 0..DEPTH;
  - in-flight counter `inf`, range 0..DEPTH.
- Credit rule: `issue_ok = (occ + inf) < DEPTH`. It is computed from registered state only, with no combinational path from any input.
- `inf` update per cycle:
  - +1 on `issue`;
  - −1 on `commit`;
  - unchanged when both occur in the same cycle.
  - Saturates at 0 and at DEPTH.
- Push: on `commit`, `longP` is written at `wp`, then `wp` increments.
- Pop: on `res_val & res_rdy`, `rp` increments.
- `occ` update: push and pop in the same cycle leaves `occ` unchanged.
- Full FIFO with simultaneous commit and pop: the push is accepted.
- `err` is set by any of the following, and is cleared only by reset:
  - `issue` while `issue_ok` is low. The issue is still counted, subject to saturation.
  - `commit` while `inf == 0`. The data is still pushed if there is space.
  - `commit` while the FIFO is full and no pop occurs. The data is dropped and the pointers hold.
- `res` shows the entry at `rp`, and holds its value while `res_val & !res_rdy`.
- `count` = `occ`.

## Timing
- Reset values:
  - `res_val` = 0, `res` = 0, `count` = 0, `err` = 0;
  - `issue_ok` = 1;
  - all pointers and counters = 0.
- Assertion of `reset` mid-operation discards all buffered and in-flight bookkeeping immediately.
- Latency without bypass: `commit` at edge t makes `res_val` high after edge t, so the product is visible in cycle t+1.
- Throughput: one push and one pop per cycle sustained.
- `issue_ok` reflects the state after the previous edge. An issue at edge t consumes a credit, which is visible as reduced `issue_ok` in cycle t+1.
- Credit return:
  - a pop at edge t raises `issue_ok` in cycle t+1;
  - a commit alone moves a credit from `inf` to `occ`, so `issue_ok` does not change.

## Configuration
- Macro `INTMUL_RESBUF_BYPASS_EN`.
- Defined: when the FIFO is empty and `commit` is high, `res_val` = 1 and `res` = `longP` combinationally in the same cycle.
  - If `res_rdy` is also high, the product is consumed with no write into the FIFO.
  - If `res_rdy` is low, the product is written as normal.
- Undefined: no input-to-output combinational path; minimum latency 1 cycle.

## Structure
- Package `intmul_pkg` contains:
  - `OPND_W` = 32 and `PROD_W` = 64;
  - `RESBUF_DEPTH_DEF` = 4;
  - typedef `prod_t` (logic [63:0]).
- The multiplier and its testbench share this package.
- Sub-module `intmul_credit_ctr` holds `inf`, the saturation logic and the `issue_ok` compare, taking `occ` as an input.
- The FIFO storage and pointers stay in the top module.

## Test plan
- Reset then idle:
  - required: `issue_ok` = 1, `res_val` = 0, `count` = 0, `err` = 0.
- Issue 4 operations, commit 0x1, 0x2, 0x3, 0xFFFF_FFFF_0000_0001 four cycles later each, with `res_rdy` = 0:
  - after the 4th issue, `issue_ok` = 0;
  - after the last commit, `count` = 4;
  - with `res_rdy` = 1, the products pop in the same order;
  - `issue_ok` returns to 1 the cycle after the first pop.
- Back-to-back issue/commit with `res_rdy` held at 1 for 20 operations:
  - one product per cycle, `count` never exceeds 1, `err` = 0.
- Full FIFO (`count` = 4) with commit 0xAA, no pop:
  - 0xAA dropped, `err` = 1, `count` stays 4.
- Commit with `inf` = 0 on an empty FIFO:
  - `err` = 1, `count` = 1.
- Reset asserted while `count` = 3 and `inf` = 1:
  - immediately `res_val` = 0 and `count` = 0;
  - after release, `issue_ok` = 1.
- With `INTMUL_RESBUF_BYPASS_EN` defined, commit 0x1234 into an empty FIFO with `res_rdy` = 1:
  - `res` = 0x1234 and `res_val` = 1 in the same cycle;
  - `count` stays 0.
